// File: rtl/glm_writeback_mc.sv
// Multi-channel writeback engine: streams cfg_length lines from one channel or a
// round-robin channel set to host memory with strided addresses and a bounded ack window.
module glm_writeback_mc #(
  parameter int NUM_CHANNELS    = 4,
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 42,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               op_start,
  input  logic [ADDR_WIDTH-1:0]              cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]               cfg_length,
  input  logic [LEN_WIDTH-1:0]               cfg_stride,
  input  logic                               cfg_interleave,
  input  logic [3:0]                         cfg_channel,
  input  logic [NUM_CHANNELS-1:0]            cfg_chmask,
  input  logic                               cfg_fence,
  input  logic [NUM_CHANNELS-1:0]            ch_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CHANNELS-1:0]            ch_ready,
  input  logic                               wr_almostfull,
  output logic                               wr_valid,
  output logic [ADDR_WIDTH-1:0]              wr_addr,
  output logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               wr_ack,
  output logic                               busy,
  output logic                               op_done,
  output logic                               op_err
);

  localparam int CH_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [CH_W-1:0] first_set(input logic [NUM_CHANNELS-1:0] mask);
    logic [CH_W-1:0] r;
    r = '0;
    for (int j = NUM_CHANNELS - 1; j >= 0; j--) begin
      if (mask[j]) r = CH_W'(j);
    end
    return r;
  endfunction

  // Next set bit strictly above cur, otherwise wrap to the lowest set bit.
  function automatic logic [CH_W-1:0] next_set(input logic [NUM_CHANNELS-1:0] mask,
                                               input logic [CH_W-1:0]         cur);
    logic [CH_W-1:0] above;
    logic            found;
    above = '0;
    found = 1'b0;
    for (int j = NUM_CHANNELS - 1; j >= 0; j--) begin
      if (mask[j] && (CH_W'(j) > cur)) begin
        above = CH_W'(j);
        found = 1'b1;
      end
    end
    return found ? above : first_set(mask);
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    stride_q, stride_d;
  logic [LEN_WIDTH-1:0]    length_q, length_d;
  logic [LEN_WIDTH-1:0]    sent_q, sent_d;
  logic [LEN_WIDTH-1:0]    outstanding_q, outstanding_d;
  logic                    interleave_q, interleave_d;
  logic [NUM_CHANNELS-1:0] chmask_q, chmask_d;
  logic [CH_W-1:0]         cur_q, cur_d;
  logic                    fence_q, fence_d;
  logic                    err_q, err_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    op_done_q, op_done_d;
  logic                    op_err_q, op_err_d;
  logic                    busy_q, busy_d;

  logic                    can_issue_s;
  logic                    sel_valid_s;
  logic                    accept_s;
  logic                    ack_take_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;

  // Channel handshake: only the current channel may be offered a slot.
  always_comb begin
    can_issue_s = (state_q == S_WRITE) && !wr_almostfull &&
                  (outstanding_q < LEN_WIDTH'(MAX_OUTSTANDING)) && (sent_q < length_q);
    ch_ready    = '0;
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (cur_q == CH_W'(c)) begin
        ch_ready[c] = can_issue_s;
        sel_valid_s = ch_valid[c];
        sel_data_s  = ch_data[c*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        ch_ready[c] = 1'b0;
      end
    end
    accept_s   = can_issue_s && sel_valid_s;
    ack_take_s = wr_ack && (outstanding_q != '0);
  end

  // Next-state logic for the FSM, datapath counters and registered outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    length_d      = length_q;
    sent_d        = sent_q;
    interleave_d  = interleave_q;
    chmask_d      = chmask_q;
    cur_d         = cur_q;
    fence_d       = fence_q;
    err_d         = err_q;
    wr_valid_d    = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    op_done_d     = (state_q == S_DONE);
    op_err_d      = (state_q == S_DONE) && err_q;

    // Acks are counted in every state; an ack with nothing outstanding is dropped.
    if (accept_s && !ack_take_s) begin
      outstanding_d = outstanding_q + LEN_WIDTH'(1);
    end else if (!accept_s && ack_take_s) begin
      outstanding_d = outstanding_q - LEN_WIDTH'(1);
    end else begin
      outstanding_d = outstanding_q;
    end

    case (state_q)
      S_IDLE: begin
        if (op_start) begin
          addr_d       = cfg_base_addr;
          stride_d     = (cfg_stride == '0) ? LEN_WIDTH'(1) : cfg_stride;
          length_d     = cfg_length;
          sent_d       = '0;
          interleave_d = cfg_interleave;
          chmask_d     = cfg_chmask;
          fence_d      = cfg_fence;
          cur_d        = cfg_interleave ? first_set(cfg_chmask) : cfg_channel;
          if (cfg_length == '0) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else if (cfg_interleave ? (cfg_chmask == '0)
                                      : (int'(cfg_channel) >= NUM_CHANNELS)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (accept_s) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = sel_data_s;
          addr_d     = addr_q + ADDR_WIDTH'(stride_q);
          sent_d     = sent_q + LEN_WIDTH'(1);
          cur_d      = interleave_q ? next_set(chmask_q, cur_q) : cur_q;
        end else begin
          cur_d = cur_q;
        end
        if ((sent_d == length_q) && (!fence_q || (outstanding_d == '0))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation and forgets pending acks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      length_q      <= '0;
      sent_q        <= '0;
      outstanding_q <= '0;
      interleave_q  <= 1'b0;
      chmask_q      <= '0;
      cur_q         <= '0;
      fence_q       <= 1'b0;
      err_q         <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      op_done_q     <= 1'b0;
      op_err_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      length_q      <= length_d;
      sent_q        <= sent_d;
      outstanding_q <= outstanding_d;
      interleave_q  <= interleave_d;
      chmask_q      <= chmask_d;
      cur_q         <= cur_d;
      fence_q       <= fence_d;
      err_q         <= err_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      op_done_q     <= op_done_d;
      op_err_q      <= op_err_d;
      busy_q        <= busy_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign op_done  = op_done_q;
  assign op_err   = op_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_glm_writeback_mc.sv
// Scoreboard bench for glm_writeback_mc: per-channel source streams, an ack responder,
// and a reference model that predicts every write and every completion.
module tb_glm_writeback_mc;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int LW  = 8;
  localparam int MO  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              op_start = 1'b0;
  logic [AW-1:0]     cfg_base_addr = '0;
  logic [LW-1:0]     cfg_length = '0;
  logic [LW-1:0]     cfg_stride = '0;
  logic              cfg_interleave = 1'b0;
  logic [3:0]        cfg_channel = '0;
  logic [NCH-1:0]    cfg_chmask = '0;
  logic              cfg_fence = 1'b0;
  logic [NCH-1:0]    ch_valid = '0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [NCH-1:0]    ch_ready;
  logic              wr_almostfull = 1'b0;
  logic              wr_valid;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_ack = 1'b0;
  logic              busy;
  logic              op_done;
  logic              op_err;

  always #5 clk = ~clk;

  glm_writeback_mc #(
    .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(rst_n), .op_start(op_start),
    .cfg_base_addr(cfg_base_addr), .cfg_length(cfg_length), .cfg_stride(cfg_stride),
    .cfg_interleave(cfg_interleave), .cfg_channel(cfg_channel), .cfg_chmask(cfg_chmask),
    .cfg_fence(cfg_fence), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .wr_almostfull(wr_almostfull), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .op_done(op_done), .op_err(op_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic err;
    int   kind;   // 0: rejected/empty, 1: unfenced, 2: fenced
    int   start;
  } done_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    ack_due[$];

  logic [DW-1:0]  srcmem [NCH][64];
  int             src_ptr [NCH];
  logic [NCH-1:0] src_en = '1;
  bit rand_valid = 0;
  bit rand_af = 0;
  bit acks_on = 1;
  bit extra_ack = 0;
  int ack_delay_fixed = 0;
  int last_due = 0;
  int last_ack_cyc = -100;
  int last_wr_cyc = -100;
  int op_writes = 0;

  wr_t   mw;
  done_t md;
  int    ecyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a completion.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid) begin
        op_writes++;
        last_wr_cyc = cyc;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none", wr_addr, wr_data);
        end else begin
          mw = exp_wr.pop_front();
          chk("wr_addr", longint'(wr_addr), longint'(mw.addr));
          chk("wr_data", longint'(wr_data), longint'(mw.data));
        end
      end
      if (op_done) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got op_done=1 at cycle %0d, required 0", cyc);
        end else begin
          md = exp_done.pop_front();
          if (md.kind == 0) ecyc = md.start + 2;
          else if (md.kind == 1) ecyc = last_wr_cyc + 1;
          else ecyc = (last_wr_cyc + 1 > last_ack_cyc + 2) ? last_wr_cyc + 1 : last_ack_cyc + 2;
          chk("op_err", longint'(op_err), longint'(md.err));
          chk("done_cycle", longint'(cyc), longint'(ecyc));
          chk("writes_left_at_done", longint'(exp_wr.size()), 0);
        end
      end
    end
  end

  // One clock of stimulus: source handshakes and ack scheduling, then drive new inputs.
  task automatic step();
    int due;
    @(negedge clk);
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_valid[c] && ch_ready[c]) src_ptr[c]++;
      end
      if (wr_valid) begin
        due = cyc + ((ack_delay_fixed > 0) ? ack_delay_fixed : int'($urandom_range(1, 12)));
        if (due < last_due) due = last_due;
        last_due = due;
        ack_due.push_back(due);
      end
    end
    @(posedge clk);
    #1;
    wr_ack = 1'b0;
    if (extra_ack) begin
      wr_ack = 1'b1;
      extra_ack = 0;
    end else if (acks_on && ack_due.size() > 0 && ack_due[0] <= cyc) begin
      void'(ack_due.pop_front());
      wr_ack = 1'b1;
      last_ack_cyc = cyc;
    end
    wr_almostfull = rand_af && ($urandom_range(0, 4) == 0);
    for (int c = 0; c < NCH; c++) begin
      ch_valid[c] = src_en[c] && (!rand_valid || ($urandom_range(0, 3) != 0));
      ch_data[c*DW +: DW] = srcmem[c][src_ptr[c] % 64];
    end
  endtask

  // Reference model: channel order, addresses and per-channel stream consumption.
  task automatic start_op(input logic [AW-1:0] base, input int len, input int stride,
                          input bit il, input int chan, input logic [NCH-1:0] mask,
                          input bit fence);
    int    order[$];
    int    m[NCH];
    int    eff;
    int    c;
    bit    bad;
    wr_t   w;
    done_t d;
    for (int i = 0; i < NCH; i++) begin
      src_ptr[i] = 0;
      m[i] = 0;
      for (int j = 0; j < 64; j++) srcmem[i][j] = $urandom;
    end
    if (il) begin
      for (int i = 0; i < NCH; i++) if (mask[i]) order.push_back(i);
    end else begin
      order.push_back(chan);
    end
    bad = il ? (mask == '0) : (chan >= NCH);
    d.start = cyc;
    d.err = 1'b0;
    d.kind = 0;
    if (len == 0) begin
      d.kind = 0;
    end else if (bad) begin
      d.err = 1'b1;
    end else begin
      d.kind = fence ? 2 : 1;
      eff = (stride == 0) ? 1 : stride;
      for (int k = 0; k < len; k++) begin
        c = order[k % order.size()];
        w.addr = base + AW'(k * eff);
        w.data = srcmem[c][m[c]];
        m[c]++;
        exp_wr.push_back(w);
      end
    end
    exp_done.push_back(d);
    op_writes = 0;
    cfg_base_addr  = base;
    cfg_length     = LW'(len);
    cfg_stride     = LW'(stride);
    cfg_interleave = il;
    cfg_channel    = 4'(chan);
    cfg_chmask     = mask;
    cfg_fence      = fence;
    op_start       = 1'b1;
    step();
    op_start       = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (exp_done.size() > 0 && t < 3000) begin
      step();
      t++;
    end
    if (exp_done.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no op_done within %0d cycles, required completion", name, t);
      exp_done.delete();
      exp_wr.delete();
    end
  endtask

  task automatic drain();
    int t = 0;
    while (ack_due.size() > 0 && t < 2000) begin
      step();
      t++;
    end
    step();
    step();
  endtask

  initial begin
    #12;
    chk("rst_wr_valid", longint'(wr_valid), 0);
    chk("rst_wr_addr", longint'(wr_addr), 0);
    chk("rst_wr_data", longint'(wr_data), 0);
    chk("rst_op_done", longint'(op_done), 0);
    chk("rst_op_err", longint'(op_err), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ch_ready", longint'(ch_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    start_op(16'h1000, 4, 1, 1'b0, 2, 4'b0000, 1'b0);
    wait_done("single");
    chk("single_writes", longint'(op_writes), 4);

    drain();
    src_en = 4'b1101;
    start_op(16'h0100, 6, 2, 1'b1, 0, 4'b1011, 1'b0);
    repeat (10) step();
    chk("stall_writes", longint'(op_writes), 1);
    chk("stall_ready", longint'(ch_ready), 4'b0010);
    src_en = 4'b1111;
    wait_done("interleave");

    drain();
    ack_delay_fixed = 10;
    start_op(16'h0400, 3, 1, 1'b0, 1, 4'b0000, 1'b1);
    wait_done("fenced");
    ack_delay_fixed = 0;

    start_op(16'h0800, 5, 1, 1'b0, 5, 4'b0000, 1'b0);
    wait_done("bad_channel");
    chk("bad_channel_writes", longint'(op_writes), 0);
    start_op(16'h0800, 0, 1, 1'b0, 1, 4'b0000, 1'b0);
    wait_done("zero_length");
    start_op(16'h0800, 3, 1, 1'b1, 0, 4'b0000, 1'b1);
    wait_done("empty_mask");

    drain();
    extra_ack = 1;
    step();
    step();
    acks_on = 0;
    start_op(16'h2000, 8, 1, 1'b0, 3, 4'b0000, 1'b0);
    repeat (20) step();
    chk("window_writes", longint'(op_writes), 4);
    chk("window_ready", longint'(ch_ready), 0);
    chk("window_busy", longint'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      acks_on = 1;
      step();
      acks_on = 0;
      repeat (6) step();
      chk("window_release", longint'(op_writes), longint'(5 + i));
    end
    acks_on = 1;
    wait_done("window");

    rand_valid = 1;
    rand_af = 1;
    for (int n = 0; n < 30; n++) begin
      start_op(AW'($urandom), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20)),
               int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
               NCH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      wait_done("random");
    end
    rand_valid = 0;
    rand_af = 0;

    drain();
    start_op(16'h3000, 12, 1, 1'b1, 0, 4'b1111, 1'b0);
    repeat (4) step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_wr_valid", longint'(wr_valid), 0);
    chk("abort_wr_addr", longint'(wr_addr), 0);
    chk("abort_wr_data", longint'(wr_data), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_ch_ready", longint'(ch_ready), 0);
    exp_wr.delete();
    exp_done.delete();
    ack_due.delete();
    last_due = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    start_op(16'hFFFE, 5, 3, 1'b1, 0, 4'b0110, 1'b1);
    wait_done("after_reset");
    chk("after_reset_writes", longint'(op_writes), 5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/glm_writeback_mc.md
# glm_writeback_mc

Parametrised multi-channel writeback engine for the GLM accelerator pipeline. On each `op_start` it streams a configured number of cache lines from one or more on-chip read channels (BRAM read front-ends) to host memory over a generic write-request port. It adds the following to the single-channel writeback:
- a strided address pattern;
- a round-robin interleave mode across a channel mask;
- a bounded outstanding-write window;
- an error flag.

## Interface
Parameters:
- `NUM_CHANNELS`, 4, number of source channels (1..16).
- `DATA_WIDTH`, 512, line width in bits.
- `ADDR_WIDTH`, 42, line-address width.
- `LEN_WIDTH`, 16, width of the length, stride and counters.
- `MAX_OUTSTANDING`, 64, maximum issued-but-unacked writes (power of two, ≤ 2^LEN_WIDTH−1).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `op_start` in 1: one-cycle pulse; samples `cfg_*`; ignored unless IDLE.
- `cfg_base_addr` in ADDR_WIDTH: first line address.
- `cfg_length` in LEN_WIDTH: lines to write.
- `cfg_stride` in LEN_WIDTH: line-address increment per beat; 0 is treated as 1.
- `cfg_interleave` in 1: 0 = single channel, 1 = round-robin over `cfg_chmask`.
- `cfg_channel` in 4: source channel in single mode.
- `cfg_chmask` in NUM_CHANNELS: channel set in interleave mode.
- `cfg_fence` in 1: 1 = finish only after all acks.
- `ch_valid` in NUM_CHANNELS: per-channel data valid.
- `ch_data` in NUM_CHANNELS×DATA_WIDTH: per-channel data.
- `ch_ready` out NUM_CHANNELS: per-channel accept, combinational.
- `wr_almostfull` in 1: host write queue almost full.
- `wr_valid` out 1: write request valid, registered.
- `wr_addr` out ADDR_WIDTH: write line address, registered.
- `wr_data` out DATA_WIDTH: write data, registered.
- `wr_ack` in 1: one write completed.
- `busy` out 1: high while not IDLE.
- `op_done` out 1: one-cycle completion pulse.
- `op_err` out 1: valid with `op_done`; 1 = config rejected.

## Operation
- States:
  - IDLE:
    - `op_start` with `cfg_length`==0 → DONE, `op_err`=0.
    - Single mode with `cfg_channel`≥NUM_CHANNELS, or interleave with `cfg_chmask`==0 → DONE, `op_err`=1, no writes.
    - Otherwise → WRITE.
  - WRITE: issues beats. Non-fenced: → DONE in the cycle after the last beat is accepted. Fenced: → DONE once sent==length and outstanding==0.
  - DONE: `op_done`=1 for one cycle → IDLE.
- Current channel:
  - Single mode: always `cfg_channel`.
  - Interleave mode: starts at the lowest set bit of `cfg_chmask`. After each accepted beat it advances to the next set bit in ascending index order, wrapping. It is strictly ordered: the engine waits on the current channel and never skips it.
- `ch_ready[c]` = state==WRITE and c==current and !`wr_almostfull` and outstanding<MAX_OUTSTANDING and sent<length. All other bits are 0.
- A beat is accepted when `ch_valid[c]` and `ch_ready[c]`.
- Address for beat k: `cfg_base_addr` + k×stride, computed as a running sum modulo 2^ADDR_WIDTH (wraps silently).
- Counters:
  - sent: cleared on start.
  - outstanding: +1 per accepted beat, −1 per `wr_ack`. Both in the same cycle leaves it unchanged. It is not cleared at start, so acks from a previous non-fenced op still drain the window. A `wr_ack` at outstanding 0 is ignored (saturates).
- `wr_ack` is counted in every state, including IDLE and DONE.

## Timing
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `op_done`=0, `op_err`=0, `busy`=0, state IDLE, all counters 0, `ch_ready`=0.
- An accepted beat appears on `wr_valid`/`wr_addr`/`wr_data` the next cycle, for exactly one cycle. Peak throughput is 1 line per cycle.
- `wr_almostfull` gates acceptance combinationally. The host tolerates the ≤1 in-flight registered write.
- `op_start`→first possible `ch_ready` is 1 cycle (the WRITE entry).
- Error or zero-length `op_done` comes 2 cycles after `op_start`.
- A reset assertion mid-operation aborts immediately. No `op_done` is issued, and pending acks are forgotten.

## Test plan
- Single mode, ch 2, base 0x1000, length 4, stride 1, no fence, `ch_valid` always 1 → writes to 0x1000..0x1003 on 4 consecutive cycles with ch2 data. `op_done` is 1 cycle after the last `wr_valid`.
- Interleave, mask 4'b1011, length 6, stride 2, base 0x100 → sources ch0,1,3,0,1,3 in order, addresses 0x100,0x102,…,0x10A. Holding `ch_valid[1]` low stalls the sequence without skipping.
- Fenced, length 3, acks delayed 10 cycles → `op_done` pulses the cycle after the 3rd `wr_ack` is counted. A simultaneous beat and ack leave outstanding unchanged.
- MAX_OUTSTANDING=4, length 8, no acks → exactly 4 writes, then `ch_ready`=0. Each ack releases one more beat.
- `cfg_channel`=5 with NUM_CHANNELS=4 → `op_done`=1 and `op_err`=1 two cycles after start, with zero writes. `cfg_length`=0 → done, `op_err`=0.
- `reset` driven low mid-transfer, then released, then a new op → outputs zero asynchronously, and the new op runs from a clean state.
